exmem_memwb_pipe: RTL and testbench
===================================

# exmem_memwb_pipe

Back-end pipeline register block of the 5-stage RISC-V core. It holds the EX/MEM and MEM/WB stage registers and drives the data-memory port. It produces the `exmem_regwr`/`exmem_rd`/`memwb_regwr`/`memwb_rd` signals and the matching data values that the forwarding unit and the register-file write port consume. It also handles memory-stall hold, EX-stage flush (with deferred flush) and a retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width
- `CNTW`, 32, retire-counter width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  EX stage holds a real instruction
- `ex_regwr`  in  1  instruction writes rd
- `ex_memrd`  in  1  load
- `ex_memwr`  in  1  store
- `ex_memtoreg`  in  1  writeback selects memory data
- `ex_rd`  in  5  destination register
- `ex_alu_result`  in  XLEN  ALU result / memory address
- `ex_store_data`  in  XLEN  store data
- `flush`  in  1  kill the instruction currently in EX
- `mem_stall`  in  1  data memory not ready this cycle
- `dmem_rdata`  in  XLEN  load data, valid in the cycle `mem_stall` is low
- `dmem_addr`  out  XLEN  = `exmem_alu_result`
- `dmem_wdata`  out  XLEN  = EX/MEM store data
- `dmem_we`, `dmem_re`  out  1  EX/MEM valid & memwr / memrd
- `pipe_stall_req`  out  1  = `mem_stall`; upstream stages must hold
- `exmem_regwr`  out  1  EX/MEM valid & regwr
- `exmem_rd`  out  5  EX/MEM rd
- `exmem_memrd`  out  1  EX/MEM holds a load (for load-use detection)
- `exmem_alu_result`  out  XLEN  forwarding value from MEM
- `memwb_regwr`  out  1  MEM/WB valid & regwr
- `memwb_rd`  out  5  MEM/WB rd
- `memwb_wdata`  out  XLEN  writeback / forwarding value from WB
- `retired`  out  CNTW  count of instructions entering MEM/WB

## Operation
- Capture qualification: `regwr` is stored as `ex_regwr & (ex_rd != 0)`. x0 is never reported as written, so forwarding never selects x0.
- EX/MEM update, one per clock edge, first matching rule wins:
  - `rst`: clear all fields.
  - `mem_stall`: hold every field.
  - `flush | pending_flush`: load a bubble (valid=0, all control bits 0; rd and data are don't-care but are driven to 0).
  - Otherwise: capture the `ex_*` inputs, with valid = `ex_valid`.
- Deferred flush (`pending_flush` register):
  - Set on `flush & mem_stall`.
  - Cleared on the first edge with `mem_stall`=0, when the bubble is inserted.
  - Cleared by `rst`.
  - A flush arriving during a stall is therefore never lost.
- MEM/WB update:
  - `rst`: clear.
  - `mem_stall`: load a bubble. The MEM instruction stays in EX/MEM, so nothing is duplicated.
  - Otherwise: capture from EX/MEM. `memwb_wdata` = `dmem_rdata` if memtoreg, else `exmem_alu_result`.
- Retire counter:
  - Increments by 1 on each edge where MEM/WB captures a valid EX/MEM entry.
  - Bubbles do not count.
  - Wraps modulo 2^CNTW.
  - `rst` clears it.
- Internal state: valid bit per stage plus `pending_flush`. States, in terms of EX/MEM occupancy:
  - EMPTY to FULL on a valid capture.
  - FULL holds while `mem_stall`.
  - FULL to EMPTY/FULL on advance.

## Timing
- Reset: every output is 0, including `retired`, `pending_flush` and all data fields. Outputs are 0 the cycle after the `rst` edge. A reset mid-stall discards both stages and any pending flush.
- Latency:
  - EX input appears on `exmem_*` 1 cycle after the capture edge.
  - It appears on `memwb_*` 1 further non-stalled cycle later.
- All outputs are registers or pure functions of registers, with no combinational path from `ex_*`. Exceptions: `pipe_stall_req` (= `mem_stall`) and the data mux feeding MEM/WB.
- `dmem_we`/`dmem_re` stay asserted for every cycle of a stall. The memory must treat a repeated request as one access.
- Simultaneous events:
  - `flush` & `mem_stall`: hold, then bubble on the first free edge.
  - `flush` & `rst`: reset.
  - `mem_stall` & `rst`: reset.
- `memwb_*` fields update every non-reset cycle; there is no hold in WB.

## Test plan
- **Straight flow.** Input: `ex_valid`=1, `regwr`=1, `rd`=5, `alu`=0x10 at cycle 0.
  - Cycle 1: `exmem_regwr`=1, `exmem_rd`=5, `exmem_alu_result`=0x10.
  - Cycle 2: `memwb_rd`=5, `memwb_wdata`=0x10, `retired`=1.
- **x0 suppression.** Input: `regwr`=1, `rd`=0.
  - Required: `exmem_regwr`=0 and later `memwb_regwr`=0, while `retired` still increments.
- **Load under stall.** Input: load with `rd`=3, `alu`=0x40, then `mem_stall` high for 2 cycles, then `dmem_rdata`=0xDEAD with `mem_stall`=0.
  - During the stall: `dmem_re`=1 and `dmem_addr`=0x40 hold; `memwb_regwr`=0 (bubbles); `exmem_memrd`=1.
  - After release: `memwb_rd`=3, `memwb_wdata`=0xDEAD, `retired` +1 only.
- **Flush.**
  - `flush` with a valid EX input: next cycle `exmem_regwr`=0 and `dmem_we`=0.
  - `flush` during a stall, deasserted before the stall ends: the EX/MEM instruction completes, then a bubble appears. The deferred flush is honoured.
- **Reset mid-operation.** Input: `rst` while EX/MEM and MEM/WB are full and `pending_flush`=1.
  - Next cycle: all outputs 0.
  - The following valid input then flows normally with no stray bubble.
- **Counter wrap.** Input: CNTW=4, 17 valid instructions.
  - Required: `retired`=1 after the 17th.

Source files
------------

// File: rtl/exmem_memwb_pipe.sv
// exmem_memwb_pipe: EX/MEM and MEM/WB stage registers with stall hold, deferred flush and retire counter
module exmem_memwb_pipe #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic            i_ex_regwr,
    input  logic            i_ex_memrd,
    input  logic            i_ex_memwr,
    input  logic            i_ex_memtoreg,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_alu_result,
    input  logic [XLEN-1:0] i_ex_store_data,
    input  logic            i_flush,
    input  logic            i_mem_stall,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic            o_dmem_we,
    output logic            o_dmem_re,
    output logic            o_pipe_stall_req,
    output logic            o_exmem_regwr,
    output logic [4:0]      o_exmem_rd,
    output logic            o_exmem_memrd,
    output logic [XLEN-1:0] o_exmem_alu_result,
    output logic            o_memwb_regwr,
    output logic [4:0]      o_memwb_rd,
    output logic [XLEN-1:0] o_memwb_wdata,
    output logic [CNTW-1:0] o_retired
);
    logic            r_em_valid, r_em_regwr, r_em_memrd, r_em_memwr, r_em_memtoreg;
    logic [4:0]      r_em_rd;
    logic [XLEN-1:0] r_em_alu, r_em_sdata;
    logic            r_pend_flush;
    logic            r_wb_valid, r_wb_regwr;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_wdata;
    logic [CNTW-1:0] r_retired;
    logic [XLEN-1:0] w_wb_data;
    logic            w_kill;

    assign w_kill = i_flush | r_pend_flush;

    // EX/MEM: reset, hold on stall, bubble on (deferred) flush, else capture; x0 never reported as written
    always_ff @(posedge i_clk) begin
        if (i_rst || (!i_mem_stall && w_kill)) begin
            r_em_valid    <= 1'b0;
            r_em_regwr    <= 1'b0;
            r_em_memrd    <= 1'b0;
            r_em_memwr    <= 1'b0;
            r_em_memtoreg <= 1'b0;
            r_em_rd       <= '0;
            r_em_alu      <= '0;
            r_em_sdata    <= '0;
        end else if (!i_mem_stall) begin
            r_em_valid    <= i_ex_valid;
            r_em_regwr    <= i_ex_regwr & (i_ex_rd != 5'd0);
            r_em_memrd    <= i_ex_memrd;
            r_em_memwr    <= i_ex_memwr;
            r_em_memtoreg <= i_ex_memtoreg;
            r_em_rd       <= i_ex_rd;
            r_em_alu      <= i_ex_alu_result;
            r_em_sdata    <= i_ex_store_data;
        end
    end

    // Remember a flush seen during a stall until the first free edge inserts the bubble
    always_ff @(posedge i_clk) begin
        r_pend_flush <= i_rst ? 1'b0 : (i_mem_stall ? (r_pend_flush | i_flush) : 1'b0);
    end

    // Writeback data: load data for memtoreg instructions, ALU result otherwise
    always_comb begin
        w_wb_data = r_em_memtoreg ? i_dmem_rdata : r_em_alu;
    end

    // MEM/WB: bubble while stalled (the MEM instruction stays in EX/MEM), else advance; count retirements
    always_ff @(posedge i_clk) begin
        if (i_rst || i_mem_stall) begin
            r_wb_valid <= 1'b0;
            r_wb_regwr <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_wdata <= '0;
        end else begin
            r_wb_valid <= r_em_valid;
            r_wb_regwr <= r_em_regwr;
            r_wb_rd    <= r_em_rd;
            r_wb_wdata <= w_wb_data;
        end
        if (i_rst)
            r_retired <= '0;
        else if (!i_mem_stall && r_em_valid)
            r_retired <= r_retired + 1'b1;
    end

    assign o_dmem_addr        = r_em_alu;
    assign o_dmem_wdata       = r_em_sdata;
    assign o_dmem_we          = r_em_valid & r_em_memwr;
    assign o_dmem_re          = r_em_valid & r_em_memrd;
    assign o_pipe_stall_req   = i_mem_stall;
    assign o_exmem_regwr      = r_em_valid & r_em_regwr;
    assign o_exmem_rd         = r_em_rd;
    assign o_exmem_memrd      = r_em_valid & r_em_memrd;
    assign o_exmem_alu_result = r_em_alu;
    assign o_memwb_regwr      = r_wb_valid & r_wb_regwr;
    assign o_memwb_rd         = r_wb_rd;
    assign o_memwb_wdata      = r_wb_wdata;
    assign o_retired          = r_retired;
endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// tb_exmem_memwb_pipe: directed checks of stage flow, stall, flush, reset and retire wrap
module tb_exmem_memwb_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 0, ex_regwr = 0, ex_memrd = 0, ex_memwr = 0, ex_memtoreg = 0;
    logic [4:0]  ex_rd = 0;
    logic [31:0] ex_alu = 0, ex_sdata = 0, dmem_rdata = 0;
    logic        flush = 0, mem_stall = 0;
    logic [31:0] dmem_addr, dmem_wdata, exmem_alu, memwb_wdata;
    logic        dmem_we, dmem_re, stall_req, exmem_regwr, exmem_memrd, memwb_regwr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [3:0]  retired;
    int          n_chk = 0, n_fail = 0;

    exmem_memwb_pipe #(.XLEN(32), .CNTW(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ex_valid(ex_valid), .i_ex_regwr(ex_regwr), .i_ex_memrd(ex_memrd),
        .i_ex_memwr(ex_memwr), .i_ex_memtoreg(ex_memtoreg), .i_ex_rd(ex_rd),
        .i_ex_alu_result(ex_alu), .i_ex_store_data(ex_sdata),
        .i_flush(flush), .i_mem_stall(mem_stall), .i_dmem_rdata(dmem_rdata),
        .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_we(dmem_we),
        .o_dmem_re(dmem_re), .o_pipe_stall_req(stall_req), .o_exmem_regwr(exmem_regwr),
        .o_exmem_rd(exmem_rd), .o_exmem_memrd(exmem_memrd), .o_exmem_alu_result(exmem_alu),
        .o_memwb_regwr(memwb_regwr), .o_memwb_rd(memwb_rd), .o_memwb_wdata(memwb_wdata),
        .o_retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sd);
        ex_valid = v; ex_regwr = rw; ex_memrd = mr; ex_memwr = mw;
        ex_memtoreg = m2r; ex_rd = rd; ex_alu = alu; ex_sdata = sd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        step(); step();
        rst = 0;
        chk("rst_exmem_regwr", exmem_regwr, 0);
        chk("rst_exmem_alu", exmem_alu, 0);
        chk("rst_memwb_regwr", memwb_regwr, 0);
        chk("rst_memwb_wdata", memwb_wdata, 0);
        chk("rst_retired", retired, 0);
        chk("rst_dmem_we_re", {dmem_we, dmem_re}, 0);

        drive(1, 1, 0, 0, 0, 5'd5, 32'h10, 32'h0);
        step();
        chk("flow_exmem_regwr", exmem_regwr, 1);
        chk("flow_exmem_rd", exmem_rd, 5);
        chk("flow_exmem_alu", exmem_alu, 32'h10);
        idle();
        step();
        chk("flow_memwb_regwr", memwb_regwr, 1);
        chk("flow_memwb_rd", memwb_rd, 5);
        chk("flow_memwb_wdata", memwb_wdata, 32'h10);
        chk("flow_retired", retired, 1);

        drive(1, 1, 0, 0, 0, 5'd0, 32'h22, 32'h0);
        step();
        chk("x0_exmem_regwr", exmem_regwr, 0);
        idle();
        step();
        chk("x0_memwb_regwr", memwb_regwr, 0);
        chk("x0_retired", retired, 2);

        drive(1, 1, 1, 0, 1, 5'd3, 32'h40, 32'h0);
        step();
        chk("ld_exmem_memrd", exmem_memrd, 1);
        idle();
        mem_stall = 1;
        chk("ld_stall_req", stall_req, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ld_stall_re", dmem_re, 1);
            chk("ld_stall_addr", dmem_addr, 32'h40);
            chk("ld_stall_memwb_regwr", memwb_regwr, 0);
            chk("ld_stall_exmem_memrd", exmem_memrd, 1);
            chk("ld_stall_retired", retired, 2);
        end
        mem_stall = 0;
        dmem_rdata = 32'hDEAD;
        step();
        chk("ld_memwb_regwr", memwb_regwr, 1);
        chk("ld_memwb_rd", memwb_rd, 3);
        chk("ld_memwb_wdata", memwb_wdata, 32'hDEAD);
        chk("ld_retired", retired, 3);
        chk("ld_exmem_memrd_clr", exmem_memrd, 0);

        drive(1, 1, 0, 1, 0, 5'd7, 32'h80, 32'h5);
        flush = 1;
        step();
        flush = 0;
        chk("fl_exmem_regwr", exmem_regwr, 0);
        chk("fl_dmem_we", dmem_we, 0);

        drive(1, 1, 0, 0, 0, 5'd9, 32'h50, 32'h0);
        step();
        chk("df_exmem_rd", exmem_rd, 9);
        drive(1, 1, 0, 0, 0, 5'd10, 32'h60, 32'h0);
        flush = 1;
        mem_stall = 1;
        step();
        chk("df_hold1_rd", exmem_rd, 9);
        flush = 0;
        step();
        chk("df_hold2_rd", exmem_rd, 9);
        mem_stall = 0;
        step();
        chk("df_memwb_rd", memwb_rd, 9);
        chk("df_memwb_regwr", memwb_regwr, 1);
        chk("df_bubble_regwr", exmem_regwr, 0);
        chk("df_bubble_rd", exmem_rd, 0);
        idle();
        step();
        chk("df_bubble_wb", memwb_regwr, 0);
        chk("df_retired", retired, 4);

        drive(1, 1, 0, 0, 0, 5'd11, 32'h70, 32'h0);
        step();
        drive(1, 1, 0, 0, 0, 5'd12, 32'h74, 32'h0);
        step();
        chk("rm_memwb_rd", memwb_rd, 11);
        flush = 1;
        mem_stall = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        flush = 0;
        mem_stall = 0;
        chk("rm_exmem_regwr", exmem_regwr, 0);
        chk("rm_exmem_rd", exmem_rd, 0);
        chk("rm_memwb_regwr", memwb_regwr, 0);
        chk("rm_memwb_wdata", memwb_wdata, 0);
        chk("rm_retired", retired, 0);
        drive(1, 1, 0, 0, 0, 5'd13, 32'h90, 32'h0);
        step();
        chk("rm_next_regwr", exmem_regwr, 1);
        chk("rm_next_rd", exmem_rd, 13);
        idle();
        step();
        chk("rm_next_memwb_rd", memwb_rd, 13);
        chk("rm_next_retired", retired, 1);

        rst = 1;
        step();
        rst = 0;
        for (int i = 1; i <= 17; i++) begin
            drive(1, 1, 0, 0, 0, 5'd1, 32'(i), 32'h0);
            step();
        end
        idle();
        step();
        chk("wrap_retired", retired, 1);
        chk("wrap_memwb_wdata", memwb_wdata, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
